horner_eval: RTL and testbench
==============================

Name: horner_eval

Overview:
Parametrised successor to the fixed three-constant X/S/H datapath. It has an internal sequencer and evaluates a polynomial of degree NCOEF-1 in an input x using Horner's method: acc = c[N-1], then acc = acc*x + c[i] for i = N-2 down to 0. Coefficients live in a writable register file, and a start/busy/done handshake replaces the external mux/load controls. The block sits between the system controller and the result bus.

Parameters:
W, 16, data/coefficient/accumulator width in bits
XW, 8, input x width in bits, XW <= W; x is zero-extended to W
NCOEF, 4, number of coefficients, >= 2; polynomial degree = NCOEF-1
AW, $clog2(NCOEF), coefficient address width (derived, not overridden)

Ports:
ck  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request evaluation; sampled only in IDLE
x  input  XW  evaluation point; latched on the accepted start edge
coef_we  input  1  coefficient write strobe
coef_addr  input  AW  coefficient index; 0 = constant term
coef_wdata  input  W  coefficient value
busy  output  1  high while an evaluation is in progress
done  output  1  one-cycle pulse when result is updated
result  output  W  last evaluated value; held until the next done
ovf  output  1  overflow flag, valid with done (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE
  - all c[i]=0; busy=0, done=0, ovf=0, result=0
  - internal reg_x, acc, reg_h and idx cleared
  - rst has priority over every other input.
  - rst asserted mid-evaluation aborts it: no done pulse, result=0.
- FSM states: IDLE, MUL, ADD.
  - IDLE + start=1: reg_x<=zext(x), acc<=c[NCOEF-1], idx<=NCOEF-2, busy<=1, go to MUL.
  - MUL: reg_h<=acc*reg_x, kept to W bits; go to ADD.
  - ADD, idx>0: acc<=reg_h+c[idx], idx<=idx-1; go to MUL.
  - ADD, idx==0: result<=reg_h+c[0], done<=1, busy<=0; go to IDLE.
- done is registered. It is high for exactly the one cycle after the final ADD edge and cleared at the next edge.
- Latency: the accepted start edge is edge 0. done rises after edge 2*(NCOEF-1).
  - Example, NCOEF=4: MUL at edges 1, 3, 5; ADD at edges 2, 4, 6.
  - busy falls at the same edge done rises.
  - A new start is accepted in the cycle done is high (state is IDLE), giving back-to-back evaluations.
- start while busy: ignored, no queuing.
- Coefficient writes:
  - Accepted only when state==IDLE. Writes while busy are dropped.
  - coef_addr >= NCOEF: write ignored.
  - start and coef_we at the same IDLE edge: the write lands, but the evaluation loads the pre-write c[NCOEF-1]. Lower coefficients are read later, so they see the new value.
- Arithmetic: unsigned. The product keeps its low W bits and the sum is modulo 2^W, unless HORNER_SAT_EN is defined.
- result and ovf change only at the done edge or at reset.

Optional Feature:
- Macro: HORNER_SAT_EN.
- Defined:
  - Every product or sum whose true value exceeds 2^W-1 clamps to 2^W-1.
  - An internal sticky flag clears on the accepted start and is set by any clamp.
  - ovf<=sticky flag at the done edge.
- Undefined:
  - Arithmetic wraps modulo 2^W.
  - ovf is tied 0.
  - No saturation logic is synthesised.

Test Plan:
- Coefficient write and Horner result (W=16, NCOEF=4, XW=8): write c0..c3=1,2,3,4; start with x=2 -> busy high; done pulse after edge 6; result=0x0031 (49); ovf=0; busy=0 with done.
- Constant term: same coefficients, x=0 -> result=0x0001. Back-to-back: start asserted in the done cycle with x=3 -> next result=0x008E (142).
- Overflow: c3=0x0100, c0..c2=0, x=0x10 -> without HORNER_SAT_EN: result=0x0000, ovf=0. With HORNER_SAT_EN: result=0xFFFF, ovf=1.
- Busy protection:
  - During an evaluation, pulse start and write c0=0x00FF -> no restart; the current result uses the old c0.
  - Afterwards, c0 reads back as the old value: a new run with x=0 returns the old c0.
  - A write to coef_addr >= NCOEF (non-power-of-two NCOEF=3 build) -> no coefficient changes.
- Simultaneous start and coef_we to addr 3 (value 5) in IDLE, x=2, old coefficients 1,2,3,4 -> result=49. A following run gives 5*8+12+4+1=57 (0x0039).
- Reset mid-evaluation: assert rst at edge 3 -> busy=0 and done never pulses; result=0; all coefficients read as 0, so the next run gives result=0.

Source files
------------

// File: rtl/horner_eval.sv
// Sequenced Horner polynomial evaluator with a writable coefficient file.
// Define HORNER_SAT_EN to clamp arithmetic at 2^W-1 and report it on ovf.
module horner_eval #(
    parameter int  W     = 16,
    parameter int  XW    = 8,
    parameter int  NCOEF = 4,
    localparam int AW    = $clog2(NCOEF)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_wdata,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, MUL, ADD} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  c_q [NCOEF];
    logic [W-1:0]  reg_x_q, reg_x_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  reg_h_q, reg_h_d;
    logic [W-1:0]  result_q, result_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]  c_rd;
    logic [W-1:0]  mul_res;
    logic [W-1:0]  sum_res;
    logic          start_acc;
    logic          final_add;
    logic          addr_ok;

    assign c_rd      = c_q[idx_q];
    assign start_acc = (state_q == IDLE) && start;
    assign final_add = (state_q == ADD) && (idx_q == '0);

    // Only a non-power-of-two file can be addressed past its last entry.
    generate
        if ((1 << AW) == NCOEF) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (int'(coef_addr) < NCOEF);
        end
    endgenerate

`ifdef HORNER_SAT_EN
    logic [2*W-1:0] prod_full;
    logic [W:0]     sum_full;
    logic           mul_clamp;
    logic           sum_clamp;
    logic           sticky_q;
    logic           ovf_q;

    assign prod_full = {{W{1'b0}}, acc_q} * {{W{1'b0}}, reg_x_q};
    assign mul_clamp = |prod_full[2*W-1:W];
    assign mul_res   = mul_clamp ? '1 : prod_full[W-1:0];
    assign sum_full  = {1'b0, reg_h_q} + {1'b0, c_rd};
    assign sum_clamp = sum_full[W];
    assign sum_res   = sum_clamp ? '1 : sum_full[W-1:0];

    // The final add's own clamp must reach ovf, so it is folded in here.
    always_ff @(posedge ck) begin
        if (rst) begin
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                sticky_q <= 1'b0;
            end else if ((state_q == MUL && mul_clamp) || (state_q == ADD && sum_clamp)) begin
                sticky_q <= 1'b1;
            end
            if (final_add) begin
                ovf_q <= sticky_q | sum_clamp;
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign mul_res = acc_q * reg_x_q;
    assign sum_res = reg_h_q + c_rd;
    assign ovf     = 1'b0;
`endif

    // NOTE: the coefficient file is a small register array, so it is reset
    // like any other register; a RAM macro could not be cleared this way.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                c_q[i] <= '0;
            end
        end else if (state_q == IDLE && coef_we && addr_ok) begin
            c_q[coef_addr] <= coef_wdata;
        end
    end

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        reg_x_d  = reg_x_q;
        acc_d    = acc_q;
        reg_h_d  = reg_h_q;
        result_d = result_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    reg_x_d = W'(x);
                    acc_d   = c_q[NCOEF-1];
                    idx_d   = AW'(NCOEF - 2);
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                reg_h_d = mul_res;
                state_d = ADD;
            end
            ADD: begin
                if (final_add) begin
                    result_d = sum_res;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    acc_d   = sum_res;
                    idx_d   = idx_q - AW'(1);
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= IDLE;
            reg_x_q  <= '0;
            acc_q    <= '0;
            reg_h_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_x_q  <= reg_x_d;
            acc_q    <= acc_d;
            reg_h_q  <= reg_h_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_horner_eval.sv
// Bench for horner_eval: cycle-level reference model plus directed vectors
// with literal expectations; a second NCOEF=3 instance covers address range.
module tb_horner_eval;

    localparam int W  = 16;
    localparam int XW = 8;
    localparam int N  = 4;
`ifdef HORNER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          ck = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] x;
    logic          coef_we;
    logic [1:0]    coef_addr;
    logic [W-1:0]  coef_wdata;
    logic          busy, done, ovf;
    logic [W-1:0]  result;

    logic          start3;
    logic [XW-1:0] x3;
    logic          coef_we3;
    logic [1:0]    coef_addr3;
    logic [W-1:0]  coef_wdata3;
    logic          busy3, done3, ovf3;
    logic [W-1:0]  result3;

    int n_err = 0;
    int n_chk = 0;

    horner_eval #(.W(W), .XW(XW), .NCOEF(N)) dut (
        .ck(ck), .rst(rst), .start(start), .x(x), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    horner_eval #(.W(W), .XW(XW), .NCOEF(3)) dut3 (
        .ck(ck), .rst(rst), .start(start3), .x(x3), .coef_we(coef_we3),
        .coef_addr(coef_addr3), .coef_wdata(coef_wdata3),
        .busy(busy3), .done(done3), .result(result3), .ovf(ovf3)
    );

    always #5 ck = ~ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-integer Horner evaluation; the top coefficient is passed separately
    // because it is captured before a same-edge write lands.
    function automatic logic [W-1:0] horner_ref(input logic [W-1:0] top,
                                                input logic [W-1:0] cs [N],
                                                input logic [XW-1:0] xv,
                                                output bit ov);
        longint acc, p, s;
        ov  = 1'b0;
        acc = top;
        for (int i = N - 2; i >= 0; i--) begin
            p = acc * longint'(xv);
            if (p > 65535) begin
                if (SAT) begin p = 65535; ov = 1'b1; end
                else p = p % 65536;
            end
            s = p + longint'(cs[i]);
            if (s > 65535) begin
                if (SAT) begin s = 65535; ov = 1'b1; end
                else s = s % 65536;
            end
            acc = s;
        end
        return acc[W-1:0];
    endfunction

    logic [W-1:0] m_c [N];
    logic [W-1:0] m_res, m_pend, old_top;
    bit           m_busy, m_done, m_ovf, m_pend_ov, m_ready = 1'b0;
    int           m_rem;

    always @(posedge ck) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_res = '0; m_rem = 0;
            foreach (m_c[i]) m_c[i] = '0;
            m_ready = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_res = m_pend; m_ovf = m_pend_ov;
                end
            end else begin
                old_top = m_c[N-1];
                if (coef_we) m_c[coef_addr] = coef_wdata;
                if (start) begin
                    m_pend = horner_ref(old_top, m_c, x, m_pend_ov);
                    m_busy = 1'b1;
                    m_rem  = 2 * (N - 1);
                end
            end
        end
    end

    always @(negedge ck) begin
        if (m_ready) begin
            check("cmp_busy", 32'(busy), 32'(m_busy));
            check("cmp_done", 32'(done), 32'(m_done));
            check("cmp_result", 32'(result), 32'(m_res));
            check("cmp_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        tick;
        coef_we = 1'b0;
    endtask

    task automatic launch(input logic [XW-1:0] xv);
        start = 1'b1; x = xv;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat,
                             input logic [W-1:0] exp_res, input logic exp_ov);
        int k;
        for (k = 1; k <= 20; k++) begin
            tick;
            if (done === 1'b1) break;
        end
        check({name, "_lat"}, 32'(k), 32'(exp_lat));
        check({name, "_result"}, 32'(result), 32'(exp_res));
        check({name, "_ovf"}, 32'(ovf), 32'(exp_ov));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int dcount;
        rst = 1'b1; start = 1'b0; x = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        start3 = 1'b0; x3 = '0; coef_we3 = 1'b0; coef_addr3 = '0; coef_wdata3 = '0;
        tick;
        tick;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // NCOEF=3 instance: c = 1,2,3 then an out-of-range write to index 3.
        for (int i = 0; i < 4; i++) begin
            coef_we3 = 1'b1; coef_addr3 = 2'(i); coef_wdata3 = (i == 3) ? 16'h0077 : 16'(i + 1);
            tick;
        end
        coef_we3 = 1'b0;
        start3 = 1'b1; x3 = 8'd2;
        tick;
        start3 = 1'b0;
        for (k = 1; k <= 20; k++) begin
            tick;
            if (done3 === 1'b1) break;
        end
        check("n3_lat", 32'(k), 32'd4);
        check("n3_result", 32'(result3), 32'h0011);

        // Basic evaluation: 4x^3+3x^2+2x+1 at x=2.
        wr(2'd0, 16'd1); wr(2'd1, 16'd2); wr(2'd2, 16'd3); wr(2'd3, 16'd4);
        launch(8'd2);
        check("t1_busy_high", 32'(busy), 32'd1);
        wait_done("t1", 6, 16'h0031, 1'b0);

        // Constant term, then a start in the done cycle.
        launch(8'd0);
        wait_done("t2_const", 6, 16'h0001, 1'b0);
        launch(8'd3);
        wait_done("t2_b2b", 6, 16'h008E, 1'b0);

        // Overflow: 0x100 * 0x10^3.
        wr(2'd3, 16'h0100); wr(2'd0, 16'h0000); wr(2'd1, 16'h0000); wr(2'd2, 16'h0000);
        launch(8'h10);
        wait_done("t3_ovf", 6, SAT ? 16'hFFFF : 16'h0000, SAT);

        // Start and coefficient write while busy are both dropped.
        wr(2'd0, 16'd1); wr(2'd1, 16'd2); wr(2'd2, 16'd3); wr(2'd3, 16'd4);
        launch(8'd2);
        tick;
        start = 1'b1; x = 8'd5; coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'h00FF;
        tick;
        start = 1'b0; coef_we = 1'b0;
        wait_done("t4_busy", 4, 16'h0031, 1'b0);
        tick;
        check("t4_norestart", 32'(busy), 32'd0);
        launch(8'd0);
        wait_done("t4_oldc0", 6, 16'h0001, 1'b0);

        // Simultaneous start and write of the top coefficient.
        coef_we = 1'b1; coef_addr = 2'd3; coef_wdata = 16'd5; start = 1'b1; x = 8'd2;
        tick;
        coef_we = 1'b0; start = 1'b0;
        wait_done("t5_simul", 6, 16'h0031, 1'b0);
        launch(8'd2);
        wait_done("t5_next", 6, 16'h0039, 1'b0);

        // Reset at edge 3 of an evaluation.
        launch(8'd2);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_result", 32'(result), 32'd0);
        dcount = 0;
        repeat (10) begin
            tick;
            if (done === 1'b1) dcount++;
        end
        check("t6_nodone", 32'(dcount), 32'd0);
        launch(8'd2);
        wait_done("t6_zero", 6, 16'h0000, 1'b0);

        tick;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
